aes128_enc_iter: RTL and testbench



---
 rtl/aes_pkg.sv | 91 +++++++++
 rtl/aes_enc_round.sv | 59 +++++
 rtl/aes128_enc_iter.sv | 146 ++++++++++++++
 tb/tb_aes128_enc_iter.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// -----------------------------------------------------------------------------
// aes_pkg
// Shared AES-128 definitions for the iterative encryption core:
//   - FSM state encoding (IDLE, ROUND, DONE)
//   - round count and initial round constant
//   - S-box lookup, xtime, SubWord, MixColumns column and key expansion helpers
// Byte ordering follows FIPS-197: byte 0 lives in bits [127:120], and bytes
// fill the 4x4 state column by column (byte r+4c is row r, column c).
// -----------------------------------------------------------------------------
package aes_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } aes_state_e;

    localparam int          AES128_NR = 10;
    localparam logic [7:0]  RCON_INIT = 8'h01;

    // Forward S-box, entry 0 in the top byte.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Entry x occupies bits [2047-8x -: 8]; 2047-8x == {~x, 3'b111}.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX_TABLE[{~x, 3'b111} -: 8];
    endfunction

    // Multiply by 2 in GF(2^8) with the AES polynomial.
    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    // One MixColumns column; col = {a0, a1, a2, a3} with a0 in the top byte.
    function automatic logic [31:0] mix_column(input logic [31:0] col);
        logic [7:0] a0;
        logic [7:0] a1;
        logic [7:0] a2;
        logic [7:0] a3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    // Next AES-128 round key from the current one and this round's rcon.
    function automatic logic [127:0] key_expand(input logic [127:0] k,
                                                input logic [7:0]   rc);
        logic [31:0] w0;
        logic [31:0] w1;
        logic [31:0] w2;
        logic [31:0] w3;
        logic [31:0] t;
        w0 = k[127:96];
        w1 = k[95:64];
        w2 = k[63:32];
        w3 = k[31:0];
        t  = sub_word({w3[23:0], w3[31:24]}) ^ {rc, 24'h000000};
        w0 = w0 ^ t;
        w1 = w1 ^ w0;
        w2 = w2 ^ w1;
        w3 = w3 ^ w2;
        return {w0, w1, w2, w3};
    endfunction

endpackage

// File: rtl/aes_enc_round.sv
// -----------------------------------------------------------------------------
// aes_enc_round
// One combinational AES encryption round:
//   SubBytes -> ShiftRows -> MixColumns (bypassed when last_i) -> AddRoundKey
// Ports:
//   state_i  [127:0]  round input state (FIPS-197 byte order)
//   rkey_i   [127:0]  round key for this round
//   last_i            final round, MixColumns skipped
//   state_o  [127:0]  round output state
// -----------------------------------------------------------------------------
module aes_enc_round
    import aes_pkg::*;
(
    input  logic [127:0] state_i,
    input  logic [127:0] rkey_i,
    input  logic         last_i,
    output logic [127:0] state_o
);

    logic [127:0] sb_s;
    logic [127:0] sr_s;
    logic [127:0] mc_s;

    // SubBytes on all sixteen bytes.
    always_comb begin
        sb_s = '0;
        for (int i = 0; i < 16; i++) begin
            sb_s[127-8*i -: 8] = sbox(state_i[127-8*i -: 8]);
        end
    end

    // ShiftRows: row r rotates left by r columns.
    always_comb begin
        sr_s = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                sr_s[127-8*(r+4*c) -: 8] = sb_s[127-8*(r+4*((c+r)%4)) -: 8];
            end
        end
    end

    // MixColumns, one 32-bit column at a time.
    always_comb begin
        mc_s = '0;
        for (int c = 0; c < 4; c++) begin
            mc_s[127-32*c -: 32] = mix_column(sr_s[127-32*c -: 32]);
        end
    end

    // AddRoundKey, taking the ShiftRows result directly in the last round.
    always_comb begin
        if (last_i) begin
            state_o = sr_s ^ rkey_i;
        end else begin
            state_o = mc_s ^ rkey_i;
        end
    end

endmodule

// File: rtl/aes128_enc_iter.sv
// -----------------------------------------------------------------------------
// aes128_enc_iter
// Iterative AES-128 encryption core: one round per clock with the round key
// expanded on the fly, valid/ready handshakes on input and output.
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   plaintext/key presented
//   in_ready   core can accept a block (IDLE, or DONE while the sink takes
//              the current result)
//   data_in    [127:0] plaintext, byte 0 in [127:120]
//   key_in     [127:0] cipher key, same order
//   out_valid  ciphertext valid, held until out_ready
//   out_ready  sink accepts ciphertext
//   data_out   [127:0] ciphertext (0 whenever out_valid is low)
//   busy       rounds in progress
// Parameters:
//   NR         round count, must be 10
//   ZEROIZE    clear state and key registers on the output handshake
// -----------------------------------------------------------------------------
module aes128_enc_iter
    import aes_pkg::*;
#(
    parameter int NR      = 10,
    parameter bit ZEROIZE = 1'b1
)(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] data_in,
    input  logic [127:0] key_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] data_out,
    output logic         busy
);

    if (NR != AES128_NR) begin : g_nr_bad
        $error("aes128_enc_iter: NR must be 10 for AES-128");
    end

    aes_state_e   fsm_q;
    logic [127:0] state_q;
    logic [127:0] rkey_q;
    logic [3:0]   rnd_q;
    logic [7:0]   rcon_q;
    logic         out_valid_q;
    logic         busy_q;

    logic [127:0] nkey_s;
    logic [127:0] round_out_s;
    logic         last_s;

    assign nkey_s = key_expand(rkey_q, rcon_q);
    assign last_s = (rnd_q == 4'(NR));

    aes_enc_round u_round (
        .state_i (state_q),
        .rkey_i  (nkey_s),
        .last_i  (last_s),
        .state_o (round_out_s)
    );

    // in_ready follows out_ready in DONE so a new block can load on the
    // same edge as the output handshake.
    always_comb begin
        if (fsm_q == IDLE) begin
            in_ready = 1'b1;
        end else if (fsm_q == DONE) begin
            in_ready = out_ready;
        end else begin
            in_ready = 1'b0;
        end
    end

    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign data_out  = out_valid_q ? state_q : 128'h0;

    // Control FSM and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q       <= IDLE;
            state_q     <= 128'h0;
            rkey_q      <= 128'h0;
            rnd_q       <= 4'd0;
            rcon_q      <= RCON_INIT;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (fsm_q)
                IDLE: begin
                    if (in_valid) begin
                        // Round 0 AddRoundKey happens on load.
                        state_q <= data_in ^ key_in;
                        rkey_q  <= key_in;
                        rnd_q   <= 4'd1;
                        rcon_q  <= RCON_INIT;
                        busy_q  <= 1'b1;
                        fsm_q   <= ROUND;
                    end
                end
                ROUND: begin
                    state_q <= round_out_s;
                    rkey_q  <= nkey_s;
                    rcon_q  <= xtime(rcon_q);
                    rnd_q   <= rnd_q + 4'd1;
                    if (last_s) begin
                        busy_q      <= 1'b0;
                        out_valid_q <= 1'b1;
                        fsm_q       <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        if (in_valid) begin
                            state_q     <= data_in ^ key_in;
                            rkey_q      <= key_in;
                            rnd_q       <= 4'd1;
                            rcon_q      <= RCON_INIT;
                            out_valid_q <= 1'b0;
                            busy_q      <= 1'b1;
                            fsm_q       <= ROUND;
                        end else begin
                            out_valid_q <= 1'b0;
                            rnd_q       <= 4'd0;
                            rcon_q      <= RCON_INIT;
                            fsm_q       <= IDLE;
                            if (ZEROIZE) begin
                                state_q <= 128'h0;
                                rkey_q  <= 128'h0;
                            end
                        end
                    end
                end
                default: begin
                    fsm_q       <= IDLE;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes128_enc_iter.sv
// -----------------------------------------------------------------------------
// tb_aes128_enc_iter
// Directed-vector bench for aes128_enc_iter using FIPS-197 known answers.
// -----------------------------------------------------------------------------
module tb_aes128_enc_iter;

    localparam logic [127:0] K_C1   = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P_C1   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C_C1   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] K_B    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] P_B    = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] C_B    = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] C_ZERO = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] data_in;
    logic [127:0] key_in;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] data_out;
    logic         busy;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    aes128_enc_iter #(.NR(10), .ZEROIZE(1'b1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_in   (data_in),
        .key_in    (key_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data_out  (data_out),
        .busy      (busy)
    );

    task automatic check_eq(input string tag, input logic [127:0] got,
                            input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Count edges until out_valid, bounded.
    task automatic wait_valid(input string tag, output int cycles);
        cycles = 0;
        while (!out_valid && cycles < 40) begin
            tick();
            cycles++;
        end
        if (!out_valid) begin
            check_eq({tag, " timeout"}, 128'(out_valid), 128'd1);
        end
    endtask

    // Accept one block, expect the result after the accepting edge plus 10
    // round edges (11 edges in total), then hand it off.
    task automatic run_block(input string tag, input logic [127:0] k,
                             input logic [127:0] p, input logic [127:0] c);
        int lat;
        check_eq({tag, " in_ready"}, 128'(in_ready), 128'd1);
        key_in   = k;
        data_in  = p;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check_eq({tag, " busy"}, 128'(busy), 128'd1);
        wait_valid(tag, lat);
        check_eq({tag, " latency"}, 128'(lat), 128'd10);
        check_eq({tag, " data"}, data_out, c);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_eq({tag, " released"}, 128'(out_valid), 128'd0);
        check_eq({tag, " data cleared"}, data_out, 128'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        data_in   = 128'h0;
        key_in    = 128'h0;
        #2;
        check_eq("rst in_ready",  128'(in_ready),  128'd1);
        check_eq("rst out_valid", 128'(out_valid), 128'd0);
        check_eq("rst busy",      128'(busy),      128'd0);
        check_eq("rst data_out",  data_out,        128'h0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        run_block("c1", K_C1, P_C1, C_C1);
        run_block("appb", K_B, P_B, C_B);
        // Immediately after App. B: rcon must restart at 01.
        run_block("zero", 128'h0, 128'h0, C_ZERO);

        // Backpressure, with inputs toggling and in_valid raised during ROUND.
        key_in   = K_B;
        data_in  = P_B;
        in_valid = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) begin
            data_in = {$urandom, $urandom, $urandom, $urandom};
            key_in  = {$urandom, $urandom, $urandom, $urandom};
            check_eq("bp round in_ready", 128'(in_ready), 128'd0);
            tick();
        end
        wait_valid("bp", lat);
        check_eq("bp data", data_out, C_B);
        for (int i = 0; i < 20; i++) begin
            check_eq("bp hold valid",    128'(out_valid), 128'd1);
            check_eq("bp hold data",     data_out,        C_B);
            check_eq("bp hold in_ready", 128'(in_ready),  128'd0);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_eq("bp released", 128'(out_valid), 128'd0);

        // Back-to-back: C.1 then App. B with in_valid held and sink ready.
        key_in    = K_C1;
        data_in   = P_C1;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        key_in  = K_B;
        data_in = P_B;
        repeat (10) tick();
        check_eq("b2b first valid",    128'(out_valid), 128'd1);
        check_eq("b2b first data",     data_out,        C_C1);
        check_eq("b2b first in_ready", 128'(in_ready),  128'd1);
        tick();
        in_valid = 1'b0;
        check_eq("b2b second busy",    128'(busy),      128'd1);
        check_eq("b2b no bubble valid", 128'(out_valid), 128'd0);
        wait_valid("b2b", lat);
        check_eq("b2b second latency", 128'(lat),       128'd10);
        check_eq("b2b second data",    data_out,        C_B);
        tick();
        out_ready = 1'b0;
        check_eq("b2b released", 128'(out_valid), 128'd0);

        // Reset in the middle of round 5.
        key_in   = K_C1;
        data_in  = P_C1;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        check_eq("mid busy", 128'(busy), 128'd1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("mid rst out_valid", 128'(out_valid), 128'd0);
        check_eq("mid rst busy",      128'(busy),      128'd0);
        check_eq("mid rst data_out",  data_out,        128'h0);
        check_eq("mid rst in_ready",  128'(in_ready),  128'd1);
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        run_block("c1 after rst", K_C1, P_C1, C_C1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
